// File: rtl/sync_signal_pkg.sv
// Shared mode and state encodings for the sync_signal_gen channels.
package sync_signal_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL    = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_STRETCH  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_e;

endpackage

// File: rtl/sync_signal_ch.sv
// One signal-generator channel: edge detect, shadowed config, IDLE/HIGH/LOW FSM.
// SYNC_SIGNAL_GEN_RETRIG_EN makes ONESHOT retriggerable while HIGH.
module sync_signal_ch
    import sync_signal_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] period,
    output logic             signal_out,
    output logic             busy
);

`ifdef SYNC_SIGNAL_GEN_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] weff_q, weff_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             en_q;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             rise;
    logic             start;
    logic [CNT_W-1:0] weff_in;

    always_comb begin
        rise     = enable & ~en_q;
        weff_in  = (width == '0) ? ONE : width;
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        weff_d   = weff_q;
        period_d = period_q;
        out_d    = out_q;
        start    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                out_d = 1'b0;
                cnt_d = '0;
                // Live mode decides how to start; shadows are captured only here.
                case (mode_e'(mode))
                    MODE_LEVEL:    out_d = enable;
                    MODE_ONESHOT:  if (rise)   begin start = 1'b1; cnt_d = weff_in - ONE; end
                    MODE_PERIODIC: if (enable) begin start = 1'b1; cnt_d = weff_in - ONE; end
                    MODE_STRETCH:  if (enable) begin start = 1'b1; cnt_d = weff_in;       end
                    default: ;
                endcase
                if (start) begin
                    state_d  = ST_HIGH;
                    out_d    = 1'b1;
                    mode_d   = mode_e'(mode);
                    weff_d   = weff_in;
                    period_d = period;
                end
            end
            ST_HIGH: begin
                case (mode_q)
                    MODE_ONESHOT: begin
                        if (RETRIG && rise) begin
                            cnt_d = weff_q - ONE;
                            out_d = 1'b1;
                        end else if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                            out_d   = 1'b0;
                        end else begin
                            cnt_d = cnt_q - ONE;
                            out_d = 1'b1;
                        end
                    end
                    MODE_PERIODIC: begin
                        if (!enable) begin
                            state_d = ST_IDLE;
                            out_d   = 1'b0;
                            cnt_d   = '0;
                        end else if (cnt_q != '0) begin
                            cnt_d = cnt_q - ONE;
                            out_d = 1'b1;
                        end else if (period_q <= weff_q) begin
                            cnt_d = weff_q - ONE;
                            out_d = 1'b1;
                        end else begin
                            state_d = ST_LOW;
                            cnt_d   = period_q - weff_q - ONE;
                            out_d   = 1'b0;
                        end
                    end
                    MODE_STRETCH: begin
                        if (enable) begin
                            cnt_d = weff_q;
                            out_d = 1'b1;
                        end else if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                            out_d   = 1'b0;
                        end else begin
                            cnt_d = cnt_q - ONE;
                            out_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        out_d   = 1'b0;
                    end
                endcase
            end
            ST_LOW: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_HIGH;
                    cnt_d   = weff_q - ONE;
                    out_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                    out_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                out_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_LEVEL;
            cnt_q    <= '0;
            weff_q   <= '0;
            period_q <= '0;
            en_q     <= 1'b0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            weff_q   <= weff_d;
            period_q <= period_d;
            en_q     <= enable;
            out_q    <= out_d;
            busy_q   <= busy_d;
        end
    end

    assign signal_out = out_q;
    assign busy       = busy_q;

endmodule

// File: rtl/sync_signal_gen.sv
// Multi-channel timed strobe/enable generator; NUM_CH independent sync_signal_ch copies.
// Optional macro SYNC_SIGNAL_GEN_RETRIG_EN selects retriggerable ONESHOT.
module sync_signal_gen
    import sync_signal_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [CNT_W*NUM_CH-1:0] width,
    input  logic [CNT_W*NUM_CH-1:0] period,
    output logic [NUM_CH-1:0]       signal_out,
    output logic [NUM_CH-1:0]       busy
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sync_signal_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .enable    (enable[i]),
            .mode      (mode[2*i +: 2]),
            .width     (width[CNT_W*i +: CNT_W]),
            .period    (period[CNT_W*i +: CNT_W]),
            .signal_out(signal_out[i]),
            .busy      (busy[i])
        );
    end

endmodule

// File: doc/sync_signal_gen.md
Name: sync_signal_gen

Overview:
- Parametrised, multi-channel successor to the single-bit registered enable-to-signal block.
- Each of NUM_CH channels drives one registered output and has four modes: level, one-shot pulse, periodic pulse train, and stretched level.
- Pulse width and period are set per channel.
- Used wherever the design needs timed strobes or enables derived from a synchronous request bit.

Parameters:
NUM_CH, 4, number of independent channels (1..32)
CNT_W, 8, width of per-channel width/period fields and internal counter

Ports:
clk  input  1  single system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  NUM_CH  per-channel request, synchronous to clk
mode  input  2*NUM_CH  per-channel mode, channel i at [2i+1:2i]
width  input  CNT_W*NUM_CH  per-channel high time in cycles, channel i at [CNT_W*i +: CNT_W]
period  input  CNT_W*NUM_CH  per-channel period in cycles (PERIODIC only), same packing
signal_out  output  NUM_CH  registered per-channel output
busy  output  NUM_CH  registered, high while the channel FSM is not IDLE

Behaviour:
- Reset:
  - Asserting reset_n low asynchronously forces signal_out=0, busy=0, all FSMs to IDLE, counters to 0, enable history to 0.
  - Reset mid-pulse aborts the pulse immediately.
- Channels are fully independent. No shared state.
- width_eff = (width==0) ? 1 : width.
- Edge detect:
  - en_q is the registered enable.
  - A rise at edge k means enable=1 at edge k and en_q=0.
- Mode sampling:
  - mode, width and period are sampled only on the IDLE->HIGH transition and held in a per-channel shadow register.
  - Changes while busy take effect at the next start.
- Output latency: signal_out changes one edge after the qualifying input is sampled. It is always a flop output, never combinational.
- FSM states: IDLE, HIGH, LOW, with a down-counter cnt.
- Mode 0 LEVEL:
  - signal_out <= enable every cycle. The FSM stays IDLE and busy=0.
  - Identical to the original single-channel behaviour.
- Mode 1 ONESHOT:
  - In IDLE, a rise moves to HIGH with out=1 and cnt=width_eff-1.
  - In HIGH with cnt>0: cnt decrements.
  - In HIGH with cnt==0: return to IDLE with out=0.
  - signal_out is high exactly width_eff cycles regardless of the enable level.
  - A rise during HIGH is ignored (see optional feature).
- Mode 2 PERIODIC:
  - In IDLE, enable=1 (level, not edge) moves to HIGH with cnt=width_eff-1.
  - HIGH with cnt==0 moves to LOW with cnt=period-width_eff-1.
  - LOW with cnt==0 moves to HIGH with cnt=width_eff-1.
  - If period<=width_eff, the channel stays in HIGH: out constantly 1 while enable=1.
  - enable=0 in HIGH or LOW returns to IDLE with out=0 at that edge (abort, no pulse completion).
- Mode 3 STRETCH:
  - out=1 while enable=1 (state HIGH, cnt reloaded to width_eff each cycle).
  - After enable falls, out stays 1 for width_eff further cycles, then returns to IDLE with out=0.
  - enable re-asserted during the tail reloads the counter and keeps out high.
- Simultaneous events:
  - Enable fall and counter expiry on the same edge: expiry wins (HIGH->IDLE in ONESHOT; in PERIODIC enable=0 wins, giving IDLE).
- Counter arithmetic: unsigned CNT_W bits, with no wrap. All reload values are computed so they never underflow.

Optional Feature:
- Macro: SYNC_SIGNAL_GEN_RETRIG_EN.
- Defined: in ONESHOT, a rise while in HIGH reloads cnt=width_eff-1, extending the pulse (retriggerable monostable).
- Undefined: a rise during HIGH is ignored and the pulse length is fixed at width_eff.

Decomposition:
- Package sync_signal_pkg holds:
  - mode encodings: MODE_LEVEL=2'd0, MODE_ONESHOT=2'd1, MODE_PERIODIC=2'd2, MODE_STRETCH=2'd3
  - state encodings: ST_IDLE, ST_HIGH, ST_LOW
- Sub-module sync_signal_ch implements one channel (FSM, counter, shadow registers, edge detect).
- The top level generate-instantiates NUM_CH copies and slices the packed buses.

Test Plan:
- Reset and LEVEL: reset_n=0 then release; ch0 mode0, enable toggled 0,1,1,0 -> signal_out[0] shows 0,1,1,0 delayed one cycle; busy[0]=0 throughout.
- ONESHOT: ch1 mode1, width=5, enable held high 20 cycles -> exactly 5 high cycles starting one edge after the rise; width=0 -> exactly 1 high cycle.
- ONESHOT retrigger: width=5, second rise 3 cycles after the first -> 5 high cycles without the macro, 8 high cycles with SYNC_SIGNAL_GEN_RETRIG_EN.
- PERIODIC: ch2 mode2, width=2, period=5, enable high 15 cycles -> pattern 1,1,0,0,0 repeated 3 times; enable dropped mid-HIGH -> out=0 next edge and busy=0; period=2 with width=3 -> constant 1.
- STRETCH: ch3 mode3, width=4, enable high 3 cycles -> out high 7 cycles; re-assert during the tail -> tail restarts after the new fall.
- Async reset mid-pulse: reset_n low during a ONESHOT width=10 pulse at cycle 4 -> signal_out and busy go 0 without waiting for a clock edge; after release, no residual pulse until a new rise.
